uart_rx_edge_sampler: RTL

- Timing front end of the UART receiver. Sits directly upstream of the receive controller FSM.
- Synchronises RX_IN to clk and counts oversampling edges and bit periods, producing edge_cnt and bit_cnt for the FSM.
- Majority-votes three mid-bit samples into one registered bit per bit period. The deserializer, parity, start and stop checkers consume that bit.
- Purely timing and sampling: makes no frame decisions.

---
 rtl/uart_rx_edge_sampler_if.sv | 24 ++
 rtl/uart_rx_edge_sampler.sv | 103 ++++++++++
 2 files changed

// File: rtl/uart_rx_edge_sampler_if.sv
// Signal bundle between the receive controller FSM (master) and the
// edge/bit timing front end (slave).
interface uart_rx_edge_sampler_if #(
  parameter int PRESCALE_W = 6
);
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] prescale;
  logic                  counter_en;
  logic                  data_samp_en;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [3:0]            bit_cnt;
  logic                  sampled_bit;
  logic                  sample_valid;

  modport master (
    output RX_IN, prescale, counter_en, data_samp_en,
    input  edge_cnt, bit_cnt, sampled_bit, sample_valid
  );

  modport slave (
    input  RX_IN, prescale, counter_en, data_samp_en,
    output edge_cnt, bit_cnt, sampled_bit, sample_valid
  );
endinterface

// File: rtl/uart_rx_edge_sampler.sv
// UART receive timing front end: synchronises RX_IN, counts oversampling
// edges and bit periods, and majority-votes three mid-bit samples per bit.
module uart_rx_edge_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int PRESCALE_W  = 6
) (
  input  logic                   clk,
  input  logic                   RST,
  uart_rx_edge_sampler_if.slave  bus
);

  logic                  w_rx_s;
  logic [PRESCALE_W-1:0] w_p_even;
  logic [PRESCALE_W-1:0] w_p;
  logic [PRESCALE_W-1:0] w_h;
  logic [PRESCALE_W-1:0] w_last;
  logic                  w_samp_en;

  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [3:0]            r_bit_cnt;
  logic                  r_s0;
  logic                  r_s1;
  logic                  r_sampled_bit;
  logic                  r_sample_valid;

  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      assign w_rx_s = bus.RX_IN;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;

      // Flops reset to the idle-high line level so no false start is seen.
      always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
          r_sync <= '1;
        end else begin
          r_sync[0] <= bus.RX_IN;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
          end
        end
      end

      assign w_rx_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // Odd prescale rounds down to even; anything under 6 is clamped to 6.
  assign w_p_even  = bus.prescale & ~PRESCALE_W'(1);
  assign w_p       = (w_p_even < PRESCALE_W'(6)) ? PRESCALE_W'(6) : w_p_even;
  assign w_h       = w_p >> 1;
  assign w_last    = w_p - PRESCALE_W'(1);
  assign w_samp_en = bus.counter_en & bus.data_samp_en;

  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (!bus.counter_en) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (r_edge_cnt >= w_last) begin
      // >= so a prescale shrunk mid-bit wraps on the very next clock.
      r_edge_cnt <= '0;
      if (r_bit_cnt != 4'd15) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
    end else begin
      r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_s0           <= 1'b1;
      r_s1           <= 1'b1;
      r_sampled_bit  <= 1'b1;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      if (w_samp_en) begin
        if (r_edge_cnt == w_h - PRESCALE_W'(1)) begin
          r_s0 <= w_rx_s;
        end
        if (r_edge_cnt == w_h) begin
          r_s1 <= w_rx_s;
        end
        if (r_edge_cnt == w_h + PRESCALE_W'(1)) begin
          r_sampled_bit  <= (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);
          r_sample_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.edge_cnt     = r_edge_cnt;
  assign bus.bit_cnt      = r_bit_cnt;
  assign bus.sampled_bit  = r_sampled_bit;
  assign bus.sample_valid = r_sample_valid;

endmodule
